fill_valve_arbiter: RTL and testbench

//  Shares one mains water-inlet valve between NUM_WASHERS washingmachine instances (laundromat bank).

---
 rtl/fill_valve_arbiter_pkg.sv | 25 ++
 rtl/fill_valve_arbiter_rr_picker.sv | 40 ++++
 rtl/fill_valve_arbiter.sv | 141 ++++++++++++++
 tb/tb_fill_valve_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_valve_arbiter_pkg.sv
// ============================================================================
// fill_valve_arbiter_pkg : shared washer-bank constants and helpers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fill_valve_arbiter_pkg;

    localparam int DEF_NUM_WASHERS = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    // Smallest r with 2**r >= value; also used by the washingmachine FSM constants.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fill_valve_arbiter_rr_picker.sv
// ============================================================================
// fill_valve_arbiter_rr_picker : combinational first-set-after-pointer picker
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_valve_arbiter_rr_picker
    import fill_valve_arbiter_pkg::*;
#(
    parameter  int N    = DEF_NUM_WASHERS,
    localparam int ID_W = clog2_f(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_onehot,
    output logic [ID_W-1:0] o_idx,
    output logic            o_valid
);

    logic [ID_W-1:0] w_cand;

    // Scan starts one past the pointer so the last winner has lowest priority.
    always_comb begin
        w_cand   = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid  = 1'b1;
                o_idx    = w_cand;
                o_onehot = N'(1) << w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fill_valve_arbiter.sv
// ============================================================================
// fill_valve_arbiter : round-robin mains inlet valve sharing for a washer bank
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_valve_arbiter
    import fill_valve_arbiter_pkg::*;
#(
    parameter  int NUM_WASHERS   = DEF_NUM_WASHERS,
    parameter  int FILL_TIMEOUT  = 1000,
    parameter  int TIMER_W       = 16,
    parameter  int SETTLE_CYCLES = 8,
    localparam int ID_W          = clog2_f(NUM_WASHERS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_WASHERS-1:0] i_fill_req,
    input  logic [NUM_WASHERS-1:0] i_level_full,
    input  logic [NUM_WASHERS-1:0] i_fault_clr,
    output logic [NUM_WASHERS-1:0] o_grant,
    output logic [ID_W-1:0]        o_owner_id,
    output logic                   o_valve_open,
    output logic [NUM_WASHERS-1:0] o_filled_pulse,
    output logic [NUM_WASHERS-1:0] o_fault,
    output logic                   o_busy
);

    localparam int SW = clog2_f(SETTLE_CYCLES) + 1;

    logic [1:0]             r_state;
    logic [NUM_WASHERS-1:0] r_grant;
    logic [ID_W-1:0]        r_owner_id;
    logic [ID_W-1:0]        r_ptr;
    logic                   r_valve_open;
    logic [NUM_WASHERS-1:0] r_filled_pulse;
    logic [NUM_WASHERS-1:0] r_fault;
    logic                   r_busy;
    logic [TIMER_W-1:0]     r_timer;
    logic [SW-1:0]          r_settle;

    logic [NUM_WASHERS-1:0] w_elig;
    logic [NUM_WASHERS-1:0] w_pick_oh;
    logic [ID_W-1:0]        w_pick_idx;
    logic                   w_pick_valid;
    logic [NUM_WASHERS-1:0] w_owner_oh;
    logic                   w_full;
    logic                   w_req;
    logic                   w_tmo;
    logic                   w_exit;
    logic [NUM_WASHERS-1:0] w_fault_set;

    assign w_elig     = i_fill_req & ~r_fault;
    assign w_owner_oh = NUM_WASHERS'(1) << r_owner_id;
    assign w_full     = i_level_full[r_owner_id];
    assign w_req      = i_fill_req[r_owner_id];
    assign w_tmo      = (r_timer == TIMER_W'(FILL_TIMEOUT - 1));
    assign w_exit     = w_full || !w_req || w_tmo;

    // A timeout only faults when neither a fill-complete nor a withdrawal wins first.
    assign w_fault_set = (r_state == ST_FILL && !w_full && w_req && w_tmo) ? w_owner_oh : '0;

    fill_valve_arbiter_rr_picker #(
        .N (NUM_WASHERS)
    ) u_picker (
        .i_req    (w_elig),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_owner_id     <= '0;
            r_ptr          <= ID_W'(NUM_WASHERS - 1);
            r_valve_open   <= 1'b0;
            r_filled_pulse <= '0;
            r_fault        <= '0;
            r_busy         <= 1'b0;
            r_timer        <= '0;
            r_settle       <= '0;
        end else begin
            r_filled_pulse <= '0;
            r_fault        <= (r_fault & ~i_fault_clr) | w_fault_set;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state      <= ST_FILL;
                        r_grant      <= w_pick_oh;
                        r_owner_id   <= w_pick_idx;
                        r_ptr        <= w_pick_idx;
                        r_valve_open <= 1'b1;
                        r_timer      <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (!w_tmo) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (w_exit) begin
                        r_state      <= ST_SETTLE;
                        r_grant      <= '0;
                        r_valve_open <= 1'b0;
                        r_settle     <= '0;
                        if (w_full) begin
                            r_filled_pulse <= w_owner_oh;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_grant      <= '0;
                    r_valve_open <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant        = r_grant;
    assign o_owner_id     = r_owner_id;
    assign o_valve_open   = r_valve_open;
    assign o_filled_pulse = r_filled_pulse;
    assign o_fault        = r_fault;
    assign o_busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fill_valve_arbiter.sv
// ============================================================================
// tb_fill_valve_arbiter : directed + random checks against a washer-bank model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fill_valve_arbiter;

    localparam int N       = 4;
    localparam int TMO     = 20;
    localparam int SETTLE  = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] fill_req;
    logic [3:0] level_full;
    logic [3:0] fault_clr;
    logic [3:0] o_grant;
    logic [1:0] o_owner_id;
    logic       o_valve_open;
    logic [3:0] o_filled_pulse;
    logic [3:0] o_fault;
    logic       o_busy;

    fill_valve_arbiter #(
        .NUM_WASHERS   (N),
        .FILL_TIMEOUT  (TMO),
        .TIMER_W       (16),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fill_req     (fill_req),
        .i_level_full   (level_full),
        .i_fault_clr    (fault_clr),
        .o_grant        (o_grant),
        .o_owner_id     (o_owner_id),
        .o_valve_open   (o_valve_open),
        .o_filled_pulse (o_filled_pulse),
        .o_fault        (o_fault),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: who holds the valve, how long it has held it, how many settle cycles remain.
    int         m_owner;
    int         m_last;
    int         m_fill;
    int         m_settle;
    logic [3:0] e_grant;
    logic [3:0] e_pulse;
    logic [3:0] e_fault;
    logic [1:0] e_id;
    logic       e_valve;
    logic       e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_outputs();
        e_grant = (m_owner >= 0) ? (4'(1) << m_owner) : 4'd0;
        e_valve = (m_owner >= 0);
        e_busy  = (m_owner >= 0) || (m_settle > 0);
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N - 1;
        m_fill   = 0;
        m_settle = 0;
        e_pulse  = '0;
        e_fault  = '0;
        e_id     = '0;
        model_outputs();
    endtask

    task automatic model_edge(input logic [3:0] req, input logic [3:0] full, input logic [3:0] clr);
        logic [3:0] set;
        logic [3:0] elig;
        bit         found;
        int         j;
        set     = '0;
        e_pulse = '0;
        if (m_owner >= 0) begin
            m_fill++;
            if (full[m_owner[1:0]]) begin
                e_pulse  = 4'(1) << m_owner;
                m_owner  = -1;
                m_settle = SETTLE;
            end else if (!req[m_owner[1:0]]) begin
                m_owner  = -1;
                m_settle = SETTLE;
            end else if (m_fill == TMO) begin
                set      = 4'(1) << m_owner;
                m_owner  = -1;
                m_settle = SETTLE;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else begin
            elig  = req & ~e_fault;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!found && elig[j[1:0]]) begin
                    found   = 1;
                    m_owner = j;
                    m_last  = j;
                    m_fill  = 0;
                    e_id    = 2'(j);
                end
            end
        end
        e_fault = (e_fault & ~clr) | set;
        model_outputs();
    endtask

    task automatic check_all();
        chk("grant",    32'(o_grant),        32'(e_grant));
        chk("owner_id", 32'(o_owner_id),     32'(e_id));
        chk("valve",    32'(o_valve_open),   32'(e_valve));
        chk("pulse",    32'(o_filled_pulse), 32'(e_pulse));
        chk("fault",    32'(o_fault),        32'(e_fault));
        chk("busy",     32'(o_busy),         32'(e_busy));
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] full, input logic [3:0] clr);
        fill_req   = req;
        level_full = full;
        fault_clr  = clr;
        @(posedge clk);
        model_edge(req, full, clr);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        fill_req   = '0;
        level_full = '0;
        fault_clr  = '0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && e_busy; i++) step(4'd0, 4'd0, 4'd0);
        step(4'd0, 4'd0, 4'd0);
    endtask

    logic [3:0] full_v;
    logic [3:0] clr_v;
    logic [3:0] req_v;
    logic [3:0] prev_grant;
    logic [3:0] order [5];
    int         n_grants;
    int         closed;
    bit         saw_pulse;

    initial begin
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        rst_n      = 1'b0;
        fill_req   = '0;
        level_full = '0;
        fault_clr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Single washer, drum full 5 cycles after grant.
        step(4'b0001, 4'd0, 4'd0);
        chk("s1_grant", 32'(o_grant), 32'h1);
        for (int i = 0; i < 5; i++) step(4'b0001, 4'd0, 4'd0);
        step(4'b0001, 4'b0001, 4'd0);
        chk("s1_pulse", 32'(o_filled_pulse), 32'h1);
        for (int i = 0; i < 10; i++) step(4'd0, 4'd0, 4'd0);
        chk("s1_busy", 32'(o_busy), 32'h0);

        // All four requesting: rotation order and closed-valve gap.
        apply_reset();
        n_grants   = 0;
        closed     = 0;
        prev_grant = '0;
        for (int i = 0; i < 70; i++) begin
            full_v = (m_owner >= 0 && m_fill >= 2) ? (4'(1) << m_owner) : 4'd0;
            step(4'hF, full_v, 4'd0);
            if (o_grant != 0 && prev_grant == 0) begin
                if (n_grants < 5) chk("s2_order", 32'(o_grant), 32'(order[n_grants]));
                if (n_grants > 0 && n_grants < 5) chk("s2_gap", 32'(closed), 32'(SETTLE + 1));
                n_grants++;
                closed = 0;
            end
            if (!o_valve_open) closed++;
            prev_grant = o_grant;
        end
        chk("s2_count", 32'(n_grants >= 5), 32'h1);
        wait_idle();

        // Stuck fill on washer 2 times out and stays locked out until cleared.
        apply_reset();
        for (int i = 0; i < 40; i++) step(4'b0100, 4'd0, 4'd0);
        chk("s3_fault", 32'(o_fault), 32'h4);
        chk("s3_locked", 32'(o_grant), 32'h0);
        step(4'b0100, 4'd0, 4'b0100);
        step(4'b0100, 4'd0, 4'd0);
        chk("s3_regrant", 32'(o_grant), 32'h4);
        wait_idle();

        // Washer 1 withdraws mid-fill; pending washer 3 follows.
        step(4'b0010, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) step(4'b1010, 4'd0, 4'd0);
        step(4'b1000, 4'd0, 4'd0);
        chk("s4_nopulse", 32'(o_filled_pulse), 32'h0);
        for (int i = 0; i < 9; i++) step(4'b1000, 4'd0, 4'd0);
        chk("s4_grant3", 32'(o_grant), 32'h8);
        wait_idle();

        // Full coinciding with timeout; then clear coinciding with timeout.
        apply_reset();
        saw_pulse = 0;
        for (int i = 0; i < 25; i++) begin
            full_v = (m_owner == 0 && m_fill == TMO - 1) ? 4'b0001 : 4'd0;
            step(4'b0001, full_v, 4'd0);
            saw_pulse |= o_filled_pulse[0];
        end
        chk("s5_pulse", 32'(saw_pulse), 32'h1);
        chk("s5_nofault", 32'(o_fault), 32'h0);
        wait_idle();
        for (int i = 0; i < 25; i++) begin
            clr_v = (m_owner == 2 && m_fill == TMO - 1) ? 4'b0100 : 4'd0;
            step(4'b0100, 4'd0, clr_v);
        end
        chk("s5_setwins", 32'(o_fault), 32'h4);
        wait_idle();

        // Asynchronous reset while washer 0 is filling.
        step(4'b0001, 4'd0, 4'd0);
        step(4'b0001, 4'd0, 4'd0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("s6_valve", 32'(o_valve_open), 32'h0);
        chk("s6_grant", 32'(o_grant), 32'h0);
        chk("s6_fault", 32'(o_fault), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'hF, 4'd0, 4'd0);
        chk("s6_first", 32'(o_grant), 32'h1);
        for (int i = 0; i < 3; i++) step(4'hF, 4'b0001, 4'd0);

        // Random traffic with sticky requests.
        req_v = 4'hF;
        for (int i = 0; i < 600; i++) begin
            req_v  = req_v ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            full_v = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            clr_v  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step(req_v, full_v, clr_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
